// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter.
// Imported by the arbiter top and its winner-pick sub-module.
package mem_port_arbiter_pkg;

  localparam int WORD_WIDTH = 32;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_e;

  localparam logic ARB_MODE_FIXED = 1'b0;
  localparam logic ARB_MODE_RR    = 1'b1;

  // Wait counter holds MEM_LAT-1, MEM_LAT is at most 4.
  localparam int CNT_W = 2;

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational winner pick: fixed priority or round-robin from ptr+1.
// Fixed mode is the round-robin search anchored at N-1.
module mem_port_arbiter_rr_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  input  logic          i_mode,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  logic [IW-1:0] w_base;
  logic [IW:0]   w_pos;

  assign w_base = (i_mode == ARB_MODE_RR) ? i_ptr : IW'(N - 1);

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_pos   = '0;
    for (int k = 1; k <= N; k++) begin
      w_pos = {1'b0, w_base} + (IW+1)'(k);
      if (w_pos >= (IW+1)'(N)) begin
        w_pos = w_pos - (IW+1)'(N);
      end
      if (!o_valid && i_req[w_pos[IW-1:0]]) begin
        o_valid               = 1'b1;
        o_idx                 = w_pos[IW-1:0];
        o_gnt[w_pos[IW-1:0]]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// N-requester arbiter sharing one single-port memory, one access in flight.
// IDLE/ISSUE/WAIT; arbitration in IDLE and in the last WAIT cycle.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int W       = WORD_WIDTH,
  parameter int N       = 3,
  parameter int MEM_LAT = 1,
  parameter int RR      = 0
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic [N-1:0]   i_req,
  input  logic [N-1:0]   i_we,
  input  logic [N*W-1:0] i_addr,
  input  logic [N*W-1:0] i_wdata,
  output logic [N-1:0]   o_gnt,
  output logic [N-1:0]   o_rvalid,
  output logic [W-1:0]   o_rdata,
  output logic           o_busy,
  output logic           o_mem_en,
  output logic           o_mem_we,
  output logic [W-1:0]   o_mem_addr,
  output logic [W-1:0]   o_mem_wdata,
  input  logic [W-1:0]   i_mem_rdata
);

  localparam int IW = $clog2(N);
  localparam logic MODE =
    (RR != 0) ? ARB_MODE_RR : ARB_MODE_FIXED;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'(MEM_LAT - 1);

  arb_state_e       r_state;
  arb_state_e       w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [IW-1:0]    r_ptr;
  logic [N-1:0]     r_oh;
  logic [N-1:0]     r_rvalid;
  logic             r_we;
  logic [W-1:0]     r_addr;
  logic [W-1:0]     r_wdata;
  logic [W-1:0]     r_rdata;

  logic [N-1:0]     w_win_oh;
  logic [IW-1:0]    w_win_idx;
  logic             w_win_valid;
  logic             w_last;
  logic             w_arb;
  logic             w_take;
  logic             w_issue;

  mem_port_arbiter_rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .i_req   (i_req),
    .i_ptr   (r_ptr),
    .i_mode  (MODE),
    .o_gnt   (w_win_oh),
    .o_idx   (w_win_idx),
    .o_valid (w_win_valid)
  );

  assign w_issue = (r_state == ARB_ISSUE);
  assign w_last  = (r_state == ARB_WAIT) && (r_cnt == '0);
  assign w_arb   = (r_state == ARB_IDLE) || w_last;
  assign w_take  = w_arb && w_win_valid;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ARB_IDLE: begin
        if (w_win_valid) w_next = ARB_ISSUE;
      end
      ARB_ISSUE: w_next = ARB_WAIT;
      ARB_WAIT: begin
        if (w_last) begin
          w_next = w_win_valid ? ARB_ISSUE : ARB_IDLE;
        end
      end
      default: w_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ARB_IDLE;
      r_cnt    <= '0;
      r_ptr    <= IW'(N - 1);
      r_oh     <= '0;
      r_rvalid <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
    end else begin
      r_state  <= w_next;
      r_rvalid <= '0;
      if (w_take) begin
        r_oh    <= w_win_oh;
        r_ptr   <= w_win_idx;
        r_we    <= i_we[w_win_idx];
        r_addr  <= i_addr[w_win_idx*W +: W];
        r_wdata <= i_wdata[w_win_idx*W +: W];
      end
      if (w_issue) begin
        r_cnt <= CNT_LOAD;
      end else if (r_state == ARB_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      // r_we still names the finishing access here
      if (w_last && !r_we) begin
        r_rvalid <= r_oh;
        r_rdata  <= i_mem_rdata;
      end
    end
  end

  assign o_gnt       = w_issue ? r_oh : '0;
  assign o_rvalid    = r_rvalid;
  assign o_rdata     = r_rdata;
  assign o_busy      = (r_state != ARB_IDLE);
  assign o_mem_en    = w_issue;
  assign o_mem_we    = w_issue && r_we;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
N-requester arbiter that shares one single-port memory between fetch, load and store channels. It generalises the fixed fetch-over-load read mux into a req/gnt/rvalid handshake with a configurable number of channels and configurable memory read latency. It supports fixed-priority and round-robin modes. It sits between the cpu core's memory interfaces and dbg_mem (or a later memory model), and replaces the separate pc/load/store clock gating with one clock domain.

Parameters:
W, `WORD_WIDTH (32), data/address width
N, 3, number of requesters (index 0 = fetch, 1 = load, 2 = store by convention; 2..8)
MEM_LAT, 1, memory read latency in cycles, range 1..4
RR, 0, 0 = fixed priority (lowest index wins), 1 = round-robin

Ports:
clk  in  1  single clock, all state on posedge
rst  in  1  synchronous, active-high reset
req  in  N  per-channel request; held with payload until gnt
we  in  N  per-channel write flag
addr  in  N*W  per-channel address, channel i at [i*W +: W]
wdata  in  N*W  per-channel write data
gnt  out  N  one-hot, one-cycle pulse: command accepted and issued
rvalid  out  N  one-hot, one-cycle pulse: rdata valid for that channel
rdata  out  W  registered read data, shared by all channels
busy  out  1  state != IDLE
mem_en  out  1  memory command strobe
mem_we  out  1  write when mem_en=1
mem_addr  out  W  memory address
mem_wdata  out  W  memory write data
mem_rdata  in  W  valid MEM_LAT cycles after the mem_en cycle

Behaviour:
- Reset (sync): state=IDLE; gnt, rvalid, mem_en, mem_we=0; mem_addr, mem_wdata, rdata=0; RR pointer=N-1, so channel 0 wins first.
- FSM: IDLE, ISSUE, WAIT. Exactly one outstanding access; no pipelining.
- Arbitration happens in IDLE, and in the last WAIT cycle (cnt==0). If any req is set, pick winner w and register its we/addr/wdata and index; next state = ISSUE. Otherwise next state = IDLE.
- ISSUE (1 cycle): mem_en=1; mem_we/mem_addr/mem_wdata come from registers; gnt[w]=1. Load cnt=MEM_LAT-1; next state = WAIT.
- WAIT (MEM_LAT cycles): decrement cnt. In the cnt==0 cycle mem_rdata is valid. If the access is a read, capture mem_rdata into rdata at that edge; rvalid[w]=1 in the following cycle. A write completes silently with no rvalid.
- Throughput: one access per MEM_LAT+1 cycles. The next ISSUE may coincide with the previous rvalid.
- Latency: req at cycle t (IDLE) -> gnt/mem_en at t+1 -> rvalid at t+2+MEM_LAT.
- Fixed priority: lowest set req index wins; higher indices may starve (intended).
- Round-robin: search starts at ptr+1 mod N; ptr := w on each arbitration win only; wraps N-1 -> 0.
- req seen in the cycle gnt is high is treated as a new request (a requester wanting a single access drops req the cycle after gnt).
- req for the channel currently outstanding is only considered at the next arbitration point.
- rdata holds its value until the next read capture.
- mem_addr/mem_wdata hold their last values when mem_en=0.
- rst during ISSUE/WAIT: access abandoned, no rvalid, no gnt; all outputs at reset values the cycle after rst.
- No combinational path from req to any output.

Decomposition:
- Shared defines (defines.v): WORD_WIDTH; ARB_IDLE/ARB_ISSUE/ARB_WAIT state encodings; ARB_MODE_FIXED/ARB_MODE_RR.
- Sub-module rr_pick: combinational, inputs req[N], ptr, mode; outputs one-hot winner and its index. Reused later for the interrupt controller.

Test Plan:
- Reset: req=3'b111 during 2 rst cycles -> gnt, rvalid, mem_en=0; busy=0; first grant after release goes to channel 0.
- Single read, MEM_LAT=1: req[1], addr=0x40 at t; model returns 0xDEADBEEF -> t+1 gnt[1]=1, mem_en=1, mem_addr=0x40, mem_we=0; t+3 rvalid=3'b010, rdata=0xDEADBEEF.
- Write: req[2], we[2]=1, addr=0x100, wdata=0x12345678 -> one cycle mem_en=mem_we=1 with those values, gnt[2]=1; rvalid stays 0; model holds 0x12345678 at 0x100.
- Contention, req=3'b111 held, MEM_LAT=1: RR=0 -> gnt[0] every 2 cycles, channels 1/2 never granted; RR=1 -> grant order 0,1,2,0,1, spaced 2 cycles.
- MEM_LAT=3 back-to-back reads on channel 0 -> mem_en pulses 4 cycles apart; each rvalid 4 cycles after its mem_en; the second ISSUE coincides with the first rvalid.
- rst asserted in the WAIT cycle of a read -> no rvalid ever appears for it; after release, a new read of 0x40 completes normally with correct data.
